// File: rtl/axilite_bk_regfile.sv
// Backend register bank behind the AXI-Lite front end: RW config regs, sampled status,
// saturating error counter, and fixed-latency read return on bk_rdata/bk_rdone.
module axilite_bk_regfile #(
  parameter int unsigned NUM_REGS   = 8,
  parameter int unsigned RD_LATENCY = 2,
  parameter logic [14:0] BASE_ADDR  = 15'h0000
) (
  input  logic                         axi_aclk,
  input  logic                         axi_aresetn,
  input  logic                         bk_wstart,
  input  logic [14:0]                  bk_waddr,
  input  logic [31:0]                  bk_wdata,
  input  logic [3:0]                   bk_wstrb,
  input  logic                         bk_rstart,
  input  logic [14:0]                  bk_raddr,
  output logic [31:0]                  bk_rdata,
  output logic                         bk_rdone,
  input  logic [31:0]                  sts_in,
  output logic [32*(NUM_REGS-2)-1:0]   cfg_out,
  output logic [15:0]                  err_cnt
);

  localparam int unsigned NCFG     = NUM_REGS - 2;
  localparam logic [14:0] STS_IDX  = 15'(NUM_REGS - 2);
  localparam logic [14:0] ERR_IDX  = 15'(NUM_REGS - 1);
  localparam logic [3:0]  LAT_LOAD = 4'(RD_LATENCY - 1);

  typedef enum logic [0:0] {RD_IDLE = 1'b0, RD_WAIT = 1'b1} rd_state_e;

  function automatic logic [14:0] word_idx(input logic [14:0] addr);
    return (addr - BASE_ADDR) >> 2;
  endfunction

  function automatic logic addr_hit(input logic [14:0] addr);
    return (addr >= BASE_ADDR) && (word_idx(addr) < 15'(NUM_REGS));
  endfunction

  function automatic logic [31:0] byte_merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                             input logic [3:0] strb);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = strb[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
    end
    return res;
  endfunction

  logic [31:0] cfg_q [NCFG];
  logic [31:0] cfg_d [NCFG];
  logic [31:0] sts_q;
  logic [15:0] err_q, err_d;
  rd_state_e   rd_state_q;
  logic [3:0]  lat_cnt_q;
  logic [31:0] hold_q;
  logic        rdone_q;
  logic [31:0] rdata_q;

  logic        w_hit, r_hit, err_clr, rd_idle, rd_acc, rd_rej;
  logic [14:0] w_idx, r_idx;
  logic [31:0] rd_val;
  logic [1:0]  err_inc;
  logic [16:0] err_sum;

  // Write decode, byte-lane merge, read capture mux and error accounting
  always_comb begin
    w_hit   = bk_wstart && addr_hit(bk_waddr);
    r_hit   = addr_hit(bk_raddr);
    w_idx   = word_idx(bk_waddr);
    r_idx   = word_idx(bk_raddr);
    err_clr = w_hit && (w_idx == ERR_IDX) && (|bk_wstrb);
    rd_idle = (rd_state_q == RD_IDLE) && !rdone_q;
    rd_acc  = bk_rstart && rd_idle;
    rd_rej  = bk_rstart && !rd_idle;

    for (int k = 0; k < NCFG; k++) begin
      if (w_hit && (w_idx == 15'(k))) begin
        cfg_d[k] = byte_merge(cfg_q[k], bk_wdata, bk_wstrb);
      end else begin
        cfg_d[k] = cfg_q[k];
      end
    end

    // Reads see the value as it stands after any same-cycle write commits
    rd_val = 32'h0;
    if (!r_hit) begin
      rd_val = 32'h0;
    end else if (r_idx == STS_IDX) begin
      rd_val = sts_q;
    end else if (r_idx == ERR_IDX) begin
      rd_val = err_clr ? 32'h0 : {16'h0, err_q};
    end else begin
      for (int k = 0; k < NCFG; k++) begin
        if (r_idx == 15'(k)) begin
          rd_val = cfg_d[k];
        end else begin
          rd_val = rd_val;
        end
      end
    end

    err_inc = {1'b0, bk_wstart && !w_hit} + {1'b0, rd_acc && !r_hit} + {1'b0, rd_rej};
    err_sum = {1'b0, err_q} + {15'h0, err_inc};
    if (err_clr) begin
      err_d = 16'h0;
    end else if (err_sum[16]) begin
      err_d = 16'hFFFF;
    end else begin
      err_d = err_sum[15:0];
    end
  end

  // Register bank state
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      for (int k = 0; k < NCFG; k++) cfg_q[k] <= 32'h0;
      sts_q <= 32'h0;
      err_q <= 16'h0;
    end else begin
      for (int k = 0; k < NCFG; k++) cfg_q[k] <= cfg_d[k];
      sts_q <= sts_in;
      err_q <= err_d;
    end
  end

  // Read latency FSM; the counter fires at 1 so the pulse lands RD_LATENCY cycles after accept
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      rd_state_q <= RD_IDLE;
      lat_cnt_q  <= 4'h0;
      hold_q     <= 32'h0;
      rdone_q    <= 1'b0;
      rdata_q    <= 32'h0;
    end else begin
      rdone_q <= 1'b0;
      rdata_q <= 32'h0;
      case (rd_state_q)
        RD_IDLE: begin
          if (rd_acc && (RD_LATENCY == 1)) begin
            rdone_q <= 1'b1;
            rdata_q <= rd_val;
          end else if (rd_acc) begin
            rd_state_q <= RD_WAIT;
            lat_cnt_q  <= LAT_LOAD;
            hold_q     <= rd_val;
          end else begin
            rd_state_q <= RD_IDLE;
          end
        end
        RD_WAIT: begin
          if (lat_cnt_q <= 4'h1) begin
            rdone_q    <= 1'b1;
            rdata_q    <= hold_q;
            rd_state_q <= RD_IDLE;
            lat_cnt_q  <= 4'h0;
          end else begin
            lat_cnt_q <= lat_cnt_q - 4'h1;
          end
        end
        default: rd_state_q <= RD_IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < NCFG; g++) begin : g_cfg
    assign cfg_out[32*g +: 32] = cfg_q[g];
  end

  assign err_cnt  = err_q;
  assign bk_rdone = rdone_q;
  assign bk_rdata = rdata_q;

endmodule

// File: tb/tb_axilite_bk_regfile.sv
// Directed bench for axilite_bk_regfile: main instance at RD_LATENCY=2 plus
// RD_LATENCY=1 and RD_LATENCY=8 instances for the latency sweep.
module tb_axilite_bk_regfile;

  logic         clk = 1'b0;
  logic         rstn;
  logic         wstart, rstart;
  logic [14:0]  waddr, raddr;
  logic [31:0]  wdata, sts, rdata;
  logic [3:0]   wstrb;
  logic         rdone;
  logic [191:0] cfg;
  logic [15:0]  err;

  logic         tie_w   = 1'b0;
  logic [14:0]  tie_a   = 15'h0;
  logic [31:0]  tie_d   = 32'h0;
  logic [3:0]   tie_s   = 4'h0;
  logic         r1_start, r8_start;
  logic [14:0]  r1_addr, r8_addr;
  logic [31:0]  r1_data, r8_data;
  logic         r1_done, r8_done;
  logic [191:0] r1_cfg, r8_cfg;
  logic [15:0]  r1_err, r8_err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  axilite_bk_regfile #(.NUM_REGS(8), .RD_LATENCY(2), .BASE_ADDR(15'h0000)) u_dut (
    .axi_aclk(clk), .axi_aresetn(rstn), .bk_wstart(wstart), .bk_waddr(waddr),
    .bk_wdata(wdata), .bk_wstrb(wstrb), .bk_rstart(rstart), .bk_raddr(raddr),
    .bk_rdata(rdata), .bk_rdone(rdone), .sts_in(sts), .cfg_out(cfg), .err_cnt(err));

  axilite_bk_regfile #(.NUM_REGS(8), .RD_LATENCY(1), .BASE_ADDR(15'h0000)) u_dut_l1 (
    .axi_aclk(clk), .axi_aresetn(rstn), .bk_wstart(tie_w), .bk_waddr(tie_a),
    .bk_wdata(tie_d), .bk_wstrb(tie_s), .bk_rstart(r1_start), .bk_raddr(r1_addr),
    .bk_rdata(r1_data), .bk_rdone(r1_done), .sts_in(sts), .cfg_out(r1_cfg), .err_cnt(r1_err));

  axilite_bk_regfile #(.NUM_REGS(8), .RD_LATENCY(8), .BASE_ADDR(15'h0000)) u_dut_l8 (
    .axi_aclk(clk), .axi_aresetn(rstn), .bk_wstart(tie_w), .bk_waddr(tie_a),
    .bk_wdata(tie_d), .bk_wstrb(tie_s), .bk_rstart(r8_start), .bk_raddr(r8_addr),
    .bk_rdata(r8_data), .bk_rdone(r8_done), .sts_in(sts), .cfg_out(r8_cfg), .err_cnt(r8_err));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [14:0] a, input logic [31:0] d, input logic [3:0] s);
    wstart = 1'b1; waddr = a; wdata = d; wstrb = s;
    step();
    wstart = 1'b0;
  endtask

  // Issue a read on the main instance (any write already set up goes in the same cycle)
  task automatic do_read(input string tag, input logic [14:0] a, input logic [31:0] exp);
    rstart = 1'b1; raddr = a;
    step();
    rstart = 1'b0; wstart = 1'b0;
    for (int j = 1; j <= 4; j++) begin
      check({tag, "_done"}, {31'h0, rdone}, {31'h0, (j == 2)});
      check({tag, "_data"}, rdata, (j == 2) ? exp : 32'h0);
      step();
    end
  endtask

  // Back-to-back reads of the status reg on the L1 or L8 instance
  task automatic sweep(input int lat);
    int cyc;
    for (int n = 0; n < 4; n++) begin
      if (lat == 1) begin r1_start = 1'b1; r1_addr = 15'h18; end
      else          begin r8_start = 1'b1; r8_addr = 15'h18; end
      step();
      r1_start = 1'b0; r8_start = 1'b0;
      cyc = 1;
      while (((lat == 1) ? r1_done : r8_done) == 1'b0 && cyc < 12) begin
        step();
        cyc++;
      end
      check($sformatf("sweep_l%0d_lat", lat), cyc, lat);
      check($sformatf("sweep_l%0d_data", lat), (lat == 1) ? r1_data : r8_data, 32'h5A5A0001);
      step();
    end
  endtask

  initial begin
    int ndone;
    rstn = 1'b0; wstart = 1'b0; rstart = 1'b0; waddr = 15'h0; raddr = 15'h0;
    wdata = 32'h0; wstrb = 4'h0; sts = 32'h5A5A0001;
    r1_start = 1'b0; r8_start = 1'b0; r1_addr = 15'h0; r8_addr = 15'h0;
    step(); step();
    check("rst_cfg", {31'h0, |cfg}, 32'h0);
    check("rst_err", {16'h0, err}, 32'h0);
    check("rst_rdone", {31'h0, rdone}, 32'h0);
    check("rst_rdata", rdata, 32'h0);
    rstn = 1'b1;
    step();

    do_write(15'h0, 32'hAABBCCDD, 4'b0011);
    check("strb_cfg0", cfg[31:0], 32'h0000CCDD);
    do_read("rd_idx0", 15'h0, 32'h0000CCDD);

    do_write(15'h4, 32'h11111111, 4'b1111);
    wstart = 1'b1; waddr = 15'h4; wdata = 32'h22220000; wstrb = 4'b1100;
    do_read("rd_merge", 15'h4, 32'h22221111);
    check("merge_cfg1", cfg[63:32], 32'h22221111);

    do_write(15'h18, 32'hFFFFFFFF, 4'b1111);
    do_read("rd_sts", 15'h18, 32'h5A5A0001);
    check("sts_err", {16'h0, err}, 32'h0);

    wstart = 1'b1; waddr = 15'h14; wdata = 32'h12345678; wstrb = 4'b1010;
    do_read("rd_par", 15'h0, 32'h0000CCDD);
    check("par_cfg5", cfg[191:160], 32'h12005600);

    // OOR write + OOR read, then a second read during RD_WAIT
    wstart = 1'b1; waddr = 15'h20; rstart = 1'b1; raddr = 15'h100;
    step();
    wstart = 1'b0;
    step();
    rstart = 1'b0;
    ndone = rdone ? 1 : 0;
    check("err_oor_data", rdata, 32'h0);
    for (int j = 0; j < 4; j++) begin
      step();
      ndone += rdone ? 1 : 0;
    end
    check("err_cnt3", {16'h0, err}, 32'd3);
    check("err_one_done", ndone, 1);
    do_write(15'h1C, 32'h0, 4'b0001);
    check("err_clear", {16'h0, err}, 32'h0);

    // Drive the counter to saturation: two error events per cycle
    wstart = 1'b1; waddr = 15'h20; rstart = 1'b1; raddr = 15'h100;
    for (int i = 0; i < 32767; i++) step();
    check("err_65534", {16'h0, err}, 32'd65534);
    rstart = 1'b0;
    step();
    check("err_sat", {16'h0, err}, 32'h0000FFFF);
    rstart = 1'b1;
    step();
    check("err_sat_hold", {16'h0, err}, 32'h0000FFFF);
    wstart = 1'b0; rstart = 1'b0;
    for (int i = 0; i < 4; i++) step();
    wstart = 1'b1; waddr = 15'h1C; wstrb = 4'b0001; rstart = 1'b1; raddr = 15'h100;
    step();
    wstart = 1'b0; rstart = 1'b0;
    check("err_clr_wins", {16'h0, err}, 32'h0);
    for (int i = 0; i < 4; i++) step();

    // Reset while a read is pending
    do_write(15'hC, 32'hDEADBEEF, 4'b1111);
    check("pre_rst_cfg3", cfg[127:96], 32'hDEADBEEF);
    rstart = 1'b1; raddr = 15'hC;
    step();
    rstart = 1'b0;
    rstn = 1'b0;
    step(); step();
    rstn = 1'b1;
    for (int j = 0; j < 5; j++) begin
      check("mid_rst_done", {31'h0, rdone}, 32'h0);
      check("mid_rst_data", rdata, 32'h0);
      step();
    end
    check("mid_rst_cfg", {31'h0, |cfg}, 32'h0);

    sweep(1);
    sweep(8);
    check("sweep_l1_err", {16'h0, r1_err}, 32'h0);
    check("sweep_l8_err", {16'h0, r8_err}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
